// File: rtl/hazard_muldiv_ctrl_pkg.sv
// Shared decode constants for the hazard / mult-div sequencing controller.
// Opcode values match what the control unit drives on alu_control.
package hazard_muldiv_ctrl_pkg;

  localparam logic [5:0] OP_MFHI  = 6'h00;
  localparam logic [5:0] OP_MFLO  = 6'h01;
  localparam logic [5:0] OP_MULT  = 6'h07;
  localparam logic [5:0] OP_MULTU = 6'h08;
  localparam logic [5:0] OP_DIV   = 6'h09;
  localparam logic [5:0] OP_DIVU  = 6'h0A;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_md_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_hl_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_MFHI, OP_MFLO: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_muldiv_ctrl_muldiv_timer.sv
// Occupancy timer for the shared mult/div unit: busy for exactly the loaded
// number of cycles, then a one-cycle done pulse as busy drops.
module muldiv_timer
  import hazard_muldiv_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  md_state_t        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_s;

  // Next-state: load on issue, count down while busy, finish on the last count.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          state_s = ST_BUSY;
          cnt_s   = load_val;
        end else begin
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      ST_BUSY: begin
        // <= 1 also retires a zero load instead of wrapping the counter
        if (cnt_r <= CNT_W'(1)) begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered busy/done; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy    <= (state_s == ST_BUSY);
      done    <= done_s;
    end
  end

endmodule

// File: rtl/hazard_muldiv_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and
// scheduling of the shared multi-cycle mult/div unit (flush > stall > issue).
module hazard_muldiv_ctrl
  import hazard_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_alu_control,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_valid,
  input  logic        ex_load_inst,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        muldiv_start,
  output logic [1:0]  muldiv_op,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [31:0] stall_cycles
);

  logic             lu_s, is_md_s, is_hl_s, md_hz_s;
  md_op_t           md_op_s;
  logic [CNT_W-1:0] load_val_s;
  logic [31:0]      stall_cnt_r;

  assign lu_s    = ex_valid & ex_load_inst & (ex_rd != 5'd0) & id_valid &
                   ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign is_md_s = id_valid & is_md_op(id_alu_control);
  assign is_hl_s = id_valid & is_hl_op(id_alu_control);
  assign md_hz_s = muldiv_busy & (is_md_s | is_hl_s);

  // Map the decoded op onto the mult/div unit's op encoding.
  always_comb begin
    md_op_s = MD_MULT;
    case (id_alu_control)
      OP_MULT:  md_op_s = MD_MULT;
      OP_MULTU: md_op_s = MD_MULTU;
      OP_DIV:   md_op_s = MD_DIV;
      OP_DIVU:  md_op_s = MD_DIVU;
      default:  md_op_s = MD_MULT;
    endcase
  end

  assign load_val_s = md_op_s[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // Pipeline control with priority flush > stall > issue; quiet during reset.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    muldiv_start = 1'b0;
    muldiv_op    = 2'd0;
    if (reset) begin
      muldiv_start = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_s | md_hz_s) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else if (is_md_s & ~muldiv_busy) begin
      muldiv_start = 1'b1;
      muldiv_op    = md_op_s;
    end else begin
      muldiv_start = 1'b0;
    end
  end

  muldiv_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (muldiv_start),
    .load_val (load_val_s),
    .busy     (muldiv_busy),
    .done     (muldiv_done)
  );

  // Saturating count of cycles spent holding the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (pc_stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_muldiv_ctrl.sv
// Self-checking bench: vector table for the single-cycle hazard decisions,
// hand sequences for mult/div occupancy, reset abandon and counter saturation.
module tb_hazard_muldiv_ctrl;
  import hazard_muldiv_ctrl_pkg::*;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, ex_valid, ex_load_inst, ex_branch_taken;
  logic [5:0]  id_alu_control;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic        muldiv_start, muldiv_busy, muldiv_done;
  logic [1:0]  muldiv_op;
  logic [31:0] stall_cycles;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_done_q[$];
  logic [31:0] exp_sc = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_control(id_alu_control),
    .id_rs(id_rs), .id_rt(id_rt), .ex_valid(ex_valid), .ex_load_inst(ex_load_inst),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .muldiv_start(muldiv_start), .muldiv_op(muldiv_op), .muldiv_busy(muldiv_busy),
    .muldiv_done(muldiv_done), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic       idv;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       exv, exl;
    logic [4:0] exrd;
    logic       br;
    logic       e_pc, e_ifs, e_fl, e_bub, e_st;
    logic [1:0] e_op;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic idv, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic exv, input logic exl,
                        input logic [4:0] exrd, input logic br);
    id_valid = idv; id_alu_control = op; id_rs = rs; id_rt = rt;
    ex_valid = exv; ex_load_inst = exl; ex_rd = exrd; ex_branch_taken = br;
  endtask

  task automatic idle_in();
    set_in(1'b0, 6'h3F, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Scoreboard: every done pulse must match the oldest expected done cycle.
  always @(negedge clk) begin
    if (muldiv_done === 1'b1) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", {31'd0, muldiv_done}, 32'd0);
      else chk("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  task automatic push_done(input int lat);
    exp_done_q.push_back(cyc + 1 + lat);
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!muldiv_busy) break;
    end
    chk("drain_busy_clear", {31'd0, muldiv_busy}, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    set_in(v.idv, v.op, v.rs, v.rt, v.exv, v.exl, v.exrd, v.br);
    #1;
    chk($sformatf("v%0d_pc_stall", idx), {31'd0, pc_stall}, {31'd0, v.e_pc});
    chk($sformatf("v%0d_ifid_stall", idx), {31'd0, ifid_stall}, {31'd0, v.e_ifs});
    chk($sformatf("v%0d_ifid_flush", idx), {31'd0, ifid_flush}, {31'd0, v.e_fl});
    chk($sformatf("v%0d_idex_bubble", idx), {31'd0, idex_bubble}, {31'd0, v.e_bub});
    chk($sformatf("v%0d_start", idx), {31'd0, muldiv_start}, {31'd0, v.e_st});
    if (v.e_st) begin
      chk($sformatf("v%0d_op", idx), {30'd0, muldiv_op}, {30'd0, v.e_op});
      push_done(v.e_op[1] ? DIVC : MULC);
    end
    if (v.e_pc) exp_sc++;
    @(posedge clk); #1;
    chk($sformatf("v%0d_stall_cycles", idx), stall_cycles, exp_sc);
    if (v.e_st) begin
      chk($sformatf("v%0d_busy", idx), {31'd0, muldiv_busy}, 32'd1);
      drain();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        idv  op     rs    rt    exv  exl  exrd  br    pc   ifs  fl   bub  st   op
    vt[0]  = '{1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 6'h20, 5'd5, 5'd3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[2]  = '{1'b1, 6'h20, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[3]  = '{1'b1, 6'h20, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[4]  = '{1'b1, 6'h20, 5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[5]  = '{1'b0, 6'h20, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[6]  = '{1'b1, 6'h20, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[7]  = '{1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[8]  = '{1'b1, 6'h20, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[9]  = '{1'b1, 6'h07, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[10] = '{1'b1, 6'h07, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[11] = '{1'b1, 6'h07, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[12] = '{1'b1, 6'h08, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[13] = '{1'b1, 6'h09, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    vt[14] = '{1'b1, 6'h0A, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[15] = '{1'b1, 6'h00, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[16] = '{1'b1, 6'h0B, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[17] = '{1'b0, 6'h07, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset held with a load-use hazard presented: everything must stay quiet.
    reset = 1'b1;
    set_in(1'b1, 6'h07, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("rst_bubble", {31'd0, idex_bubble}, 32'd0);
    chk("rst_start", {31'd0, muldiv_start}, 32'd0);
    chk("rst_busy", {31'd0, muldiv_busy}, 32'd0);
    chk("rst_done", {31'd0, muldiv_done}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    idle_in();
    reset = 1'b0;

    for (int i = 0; i < 18; i++) apply_vec(vt[i], i);

    // mult followed by mflo: mflo holds for the 4 busy cycles, goes on done.
    @(negedge clk);
    set_in(1'b1, OP_MULT, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    chk("mul_start", {31'd0, muldiv_start}, 32'd1);
    chk("mul_op", {30'd0, muldiv_op}, 32'd0);
    push_done(MULC);
    for (int i = 0; i < MULC; i++) begin
      @(negedge clk);
      set_in(1'b1, OP_MFLO, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
      chk($sformatf("mflo_busy%0d", i), {31'd0, muldiv_busy}, 32'd1);
      chk($sformatf("mflo_stall%0d", i), {31'd0, pc_stall}, 32'd1);
      exp_sc++;
    end
    @(negedge clk); #1;
    chk("mflo_done", {31'd0, muldiv_done}, 32'd1);
    chk("mflo_busy_low", {31'd0, muldiv_busy}, 32'd0);
    chk("mflo_go", {31'd0, pc_stall}, 32'd0);
    @(posedge clk); #1;
    chk("mflo_stall_cycles", stall_cycles, exp_sc);
    idle_in();

    // div then divu: divu stalls 32 cycles (a taken branch midway does not
    // abort the divide) and issues in the done cycle.
    @(negedge clk);
    set_in(1'b1, OP_DIV, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    chk("div_start", {31'd0, muldiv_start}, 32'd1);
    chk("div_op", {30'd0, muldiv_op}, 32'd2);
    push_done(DIVC);
    for (int i = 0; i < DIVC; i++) begin
      @(negedge clk);
      set_in(1'b1, OP_DIVU, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, (i == 10) ? 1'b1 : 1'b0); #1;
      if (i == 10) begin
        chk("busy_br_flush", {31'd0, ifid_flush}, 32'd1);
        chk("busy_br_nostall", {31'd0, pc_stall}, 32'd0);
      end else begin
        chk($sformatf("divu_stall%0d", i), {31'd0, pc_stall}, 32'd1);
        exp_sc++;
      end
    end
    @(negedge clk); #1;
    chk("divu_done", {31'd0, muldiv_done}, 32'd1);
    chk("divu_start", {31'd0, muldiv_start}, 32'd1);
    chk("divu_op", {30'd0, muldiv_op}, 32'd3);
    chk("divu_nostall", {31'd0, pc_stall}, 32'd0);
    push_done(DIVC);
    @(posedge clk); #1;
    chk("divu_busy", {31'd0, muldiv_busy}, 32'd1);
    chk("divu_stall_cycles", stall_cycles, exp_sc);
    drain();

    // Reset in the middle of a divide: abandoned, no done pulse.
    @(negedge clk);
    set_in(1'b1, OP_DIV, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    chk("rdiv_start", {31'd0, muldiv_start}, 32'd1);
    push_done(DIVC);
    repeat (22) @(negedge clk);
    set_in(1'b1, OP_MULT, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
    exp_done_q.delete();
    exp_sc = 32'd0;
    reset = 1'b1; #1;
    chk("rdiv_busy_async", {31'd0, muldiv_busy}, 32'd0);
    chk("rdiv_flush", {31'd0, ifid_flush}, 32'd0);
    chk("rdiv_bubble", {31'd0, idex_bubble}, 32'd0);
    chk("rdiv_stall_cycles", stall_cycles, 32'd0);
    repeat (2) @(negedge clk);
    chk("rdiv_done_low", {31'd0, muldiv_done}, 32'd0);
    reset = 1'b0;
    set_in(1'b1, OP_MULT, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    chk("post_rst_start", {31'd0, muldiv_start}, 32'd1);
    chk("post_rst_op", {30'd0, muldiv_op}, 32'd0);
    push_done(MULC);
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, muldiv_busy}, 32'd1);
    drain();

    // Saturation: preload just below the top, then keep stalling.
    @(negedge clk);
    set_in(1'b1, 6'h20, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0);
    force dut.stall_cnt_r = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_r;
    @(posedge clk); #1;
    chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    idle_in();

    repeat (3) @(negedge clk);
    chk("done_queue_empty", exp_done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
